multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter STATE_W, default 4, width of the State debug output.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 ALUOP  output  3  operation class driven to ALUControl.
REQ-007 PCEn  output  1  PC write enable = PCWrite | (PCWriteCond & Zero).
REQ-008 IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-009 ALUSrcB  output  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-010 PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 InstrDone  output  1  one-cycle pulse in the final state of each instruction.
REQ-012 IllegalOp  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
REQ-013 State  output  STATE_W  current state encoding, debug only.

Function
REQ-014 Moore FSM, states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11; 12-15 unreachable, decode to FETCH.
REQ-015 Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101, J 000010.
REQ-016 FETCH: MemRead, IRWrite, ALUSrcA=0, ALUSrcB=01, ALUOP=000, PCSource=00, PCWrite -> DECODE.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOP=000; Opcode latched into internal OpReg; next by opcode: LW/SW->MEMADR, R->EXEC, BEQ->BRANCH, ADDI/SLTI/ANDI/ORI->IEXEC, J->JUMP, other->FETCH with IllegalOp.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOP=000; OpReg LW->MEMRD, SW->MEMWR.
REQ-019 MEMRD: MemRead, IorD -> MEMWB.  MEMWB: RegWrite, MemtoReg=1, RegDst=0, InstrDone -> FETCH.
REQ-020 MEMWR: MemWrite, IorD, InstrDone -> FETCH.
REQ-021 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOP=100 -> RWB.  RWB: RegWrite, RegDst=1, MemtoReg=0, InstrDone -> FETCH.
REQ-022 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOP=101, PCWriteCond, PCSource=01, InstrDone -> FETCH.
REQ-023 IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOP from OpReg: ADDI 000, SLTI 001, ANDI 010, ORI 011 -> IWB.  IWB: RegWrite, RegDst=0, MemtoReg=0, InstrDone -> FETCH.
REQ-024 JUMP: PCWrite, PCSource=10, InstrDone -> FETCH.
REQ-025 All controls not listed for a state SHALL be 0 (ALUOP 000, muxes 00).
REQ-026 Outputs SHALL depend only on state and OpReg, never combinationally on Opcode, except IllegalOp (DECODE & unsupported Opcode) and PCEn (Zero).
REQ-027 Latency in cycles: LW 5, SW 4, R 4, I-type 4, BEQ 3, J 3, illegal 2.
REQ-028 Opcode changes outside DECODE SHALL have no effect on sequencing.

Reset
REQ-029 rst_n low SHALL force State=FETCH and OpReg=000000 immediately, regardless of clk.
REQ-030 During reset all outputs SHALL be 0 (the FETCH control assertions are gated off), including PCEn, InstrDone and IllegalOp.
REQ-031 First rising edge after rst_n deasserts SHALL begin FETCH with full FETCH outputs; reset mid-instruction SHALL abandon it with no write strobe.

Structure
REQ-032 Opcode constants, state encodings and ALUOP codes (000 add, 001 slt, 010 and, 011 or, 100 R-type, 101 sub/beq) SHALL live in a shared package also used by ALUControl.
REQ-033 Single module; next-state and output decode in separate always blocks; no sub-module.

Verification
REQ-034 LW opcode 100011 after reset -> states 0,1,2,3,4; MemRead in 0 and 3; RegWrite+MemtoReg in 4; InstrDone at cycle 5.
REQ-035 BEQ with Zero=1 -> PCEn high in BRANCH with PCSource=01, ALUOP=101; repeat with Zero=0 -> PCEn low.
REQ-036 ORI, Opcode changed to 000000 during IEXEC -> ALUOP stays 011, IWB follows, RegDst=0.
REQ-037 Opcode 111111 -> IllegalOp pulse in DECODE, next state FETCH, no write strobes.
REQ-038 rst_n pulsed low mid-MEMRD between edges -> State=0 and all outputs 0 at once; FETCH resumes on first edge after release.
REQ-039 Back-to-back R, SW, J, ADDI -> 4+4+3+4 cycles, one InstrDone each, ALUOP 100 in EXEC and 000 in IEXEC.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller and ALUControl:
// opcodes, FSM state codes, ALU operation classes and the control bundle.
package multicycle_control_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_IEXEC  = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLT = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_R   = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;

  typedef struct packed {
    logic [2:0] aluop;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI,
      OP_SLTI, OP_ANDI, OP_ORI, OP_J: op_supported = 1'b1;
      default:                        op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a multicycle MIPS-style datapath; controls depend on
// state and the opcode latched in DECODE, and are forced low while in reset.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Opcode_i,
  input  logic               Zero_i,
  output logic [2:0]         ALUOP_o,
  output logic               PCEn_o,
  output logic               IorD_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               IRWrite_o,
  output logic               MemtoReg_o,
  output logic               RegDst_o,
  output logic               RegWrite_o,
  output logic               ALUSrcA_o,
  output logic [1:0]         ALUSrcB_o,
  output logic [1:0]         PCSource_o,
  output logic               InstrDone_o,
  output logic               IllegalOp_o,
  output logic [STATE_W-1:0] State_o
);

  logic [3:0] state_q, state_d;
  logic [5:0] op_q, op_d;
  ctrl_t      ctrl, ctrl_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= 6'b000000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    op_d    = op_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        // Only DECODE looks at the live opcode; later states use op_q.
        op_d = Opcode_i;
        case (Opcode_i)
          OP_LW, OP_SW:                     state_d = S_MEMADR;
          OP_R:                             state_d = S_EXEC;
          OP_BEQ:                           state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
          OP_J:                             state_d = S_JUMP;
          default:                          state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: ctrl.alu_src_b = 2'b11;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.aluop     = ALU_R;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.aluop         = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        ctrl.instr_done    = 1'b1;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        case (op_q)
          OP_SLTI: ctrl.aluop = ALU_SLT;
          OP_ANDI: ctrl.aluop = ALU_AND;
          OP_ORI:  ctrl.aluop = ALU_OR;
          default: ctrl.aluop = ALU_ADD;
        endcase
      end
      S_IWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = 2'b10;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // State sits at FETCH during reset, so its strobes must be masked here.
  assign ctrl_g = rst_n ? ctrl : '0;

  assign ALUOP_o     = ctrl_g.aluop;
  assign PCEn_o      = ctrl_g.pc_write | (ctrl_g.pc_write_cond & Zero_i);
  assign IorD_o      = ctrl_g.iord;
  assign MemRead_o   = ctrl_g.mem_read;
  assign MemWrite_o  = ctrl_g.mem_write;
  assign IRWrite_o   = ctrl_g.ir_write;
  assign MemtoReg_o  = ctrl_g.mem_to_reg;
  assign RegDst_o    = ctrl_g.reg_dst;
  assign RegWrite_o  = ctrl_g.reg_write;
  assign ALUSrcA_o   = ctrl_g.alu_src_a;
  assign ALUSrcB_o   = ctrl_g.alu_src_b;
  assign PCSource_o  = ctrl_g.pc_source;
  assign InstrDone_o = ctrl_g.instr_done;
  assign IllegalOp_o = rst_n & (state_q == S_DECODE) & ~op_supported(Opcode_i);
  assign State_o     = STATE_W'(state_q);

endmodule
